// File: rtl/config_pkg.sv
// Shared configuration for the data-bus arbiter: master count, outstanding depth, master ID type.
package config_pkg;
  localparam int NUM_DBUS_MASTERS     = 2;
  localparam int DBUS_MAX_OUTSTANDING = 2;

  typedef logic [$clog2(NUM_DBUS_MASTERS)-1:0] dbus_mid_t;
endpackage

// File: rtl/dbus_arb_idfifo.sv
// In-order ID FIFO recording which master owns each granted-but-unanswered transaction.
module dbus_arb_idfifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_id,
  input  logic             pop,
  output logic [WIDTH-1:0] head_id,
  output logic             full,
  output logic             empty
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr, rd_ptr;
  logic [CW-1:0]    count;
  logic             do_push, do_pop;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head_id = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= next_ptr(wr_ptr);
      if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage carries only IDs qualified by count, so it needs no reset.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_id;
  end
endmodule

// File: rtl/dbus_arbiter.sv
// Round-robin OBI data-bus arbiter with in-order response routing.
// Optional stall counter (stall_cnt/stall_clr) enabled by DBUS_ARB_PERF_EN.
module dbus_arbiter
  import config_pkg::*;
#(
  parameter int NUM_MASTERS     = NUM_DBUS_MASTERS,
  parameter int MAX_OUTSTANDING = DBUS_MAX_OUTSTANDING
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_MASTERS-1:0]    m_req,
  output logic [NUM_MASTERS-1:0]    m_gnt,
  output logic [NUM_MASTERS-1:0]    m_rvalid,
  input  logic [NUM_MASTERS*32-1:0] m_addr,
  input  logic [NUM_MASTERS-1:0]    m_we,
  input  logic [NUM_MASTERS*4-1:0]  m_be,
  input  logic [NUM_MASTERS*32-1:0] m_wdata,
  output logic [31:0]               m_rdata,
  output logic                      s_req,
  input  logic                      s_gnt,
  input  logic                      s_rvalid,
  output logic [31:0]               s_addr,
  output logic                      s_we,
  output logic [3:0]                s_be,
  output logic [31:0]               s_wdata,
  input  logic [31:0]               s_rdata,
  output logic                      err_o
`ifdef DBUS_ARB_PERF_EN
  ,
  input  logic                      stall_clr,
  output logic [31:0]               stall_cnt
`endif
);
  localparam int IDW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

  typedef enum logic {IDLE, HOLD} state_t;

  state_t         state, state_nxt;
  logic [IDW-1:0] rr_ptr, sel_q, sel, win_id, cand, head_id;
  logic           win_valid, req_sel, hs, full, empty, rsp;

  function automatic logic [NUM_MASTERS-1:0] onehot(input logic [IDW-1:0] id);
    return {{(NUM_MASTERS-1){1'b0}}, 1'b1} << id;
  endfunction

  // First requester at or after rr_ptr, circularly.
  always_comb begin
    win_valid = 1'b0;
    win_id    = rr_ptr;
    cand      = rr_ptr;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      cand = IDW'((int'(rr_ptr) + i) % NUM_MASTERS);
      if (!win_valid && m_req[cand]) begin
        win_valid = 1'b1;
        win_id    = cand;
      end
    end
  end

  // HOLD freezes the selection so the address phase stays stable until grant.
  assign sel     = (state == HOLD) ? sel_q : win_id;
  assign req_sel = (state == HOLD) ? m_req[sel_q] : win_valid;
  assign s_req   = req_sel & ~full;
  assign hs      = s_req & s_gnt;
  assign m_gnt   = hs ? onehot(sel) : '0;

  assign s_addr  = m_addr[32*sel +: 32];
  assign s_we    = m_we[sel];
  assign s_be    = m_be[4*sel +: 4];
  assign s_wdata = m_wdata[32*sel +: 32];

  assign rsp      = s_rvalid & ~empty;
  assign m_rvalid = rsp ? onehot(head_id) : '0;
  assign m_rdata  = s_rdata;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (s_req && !s_gnt) state_nxt = HOLD;
      HOLD: if (hs || !m_req[sel_q]) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      rr_ptr <= '0;
      sel_q  <= '0;
      err_o  <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == IDLE) sel_q <= sel;
      if (hs) rr_ptr <= (sel == IDW'(NUM_MASTERS - 1)) ? '0 : sel + 1'b1;
      if (s_rvalid && empty) err_o <= 1'b1;
    end
  end

  dbus_arb_idfifo #(
    .DEPTH(MAX_OUTSTANDING),
    .WIDTH(IDW)
  ) u_idfifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (hs),
    .push_id (sel),
    .pop     (rsp),
    .head_id (head_id),
    .full    (full),
    .empty   (empty)
  );

`ifdef DBUS_ARB_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                 stall_cnt <= '0;
    else if (stall_clr)                         stall_cnt <= '0;
    else if (|m_req && !hs && stall_cnt != '1)  stall_cnt <= stall_cnt + 1'b1;
  end
`endif
endmodule

// File: tb/tb_dbus_arbiter.sv
// Self-checking bench for dbus_arbiter: vector table, hand sequences and response scoreboard.
module tb_dbus_arbiter;
  logic        clk, rst_n;
  logic [1:0]  m_req, m_gnt, m_rvalid, m_we;
  logic [63:0] m_addr, m_wdata;
  logic [7:0]  m_be;
  logic [31:0] m_rdata, s_addr, s_wdata, s_rdata;
  logic        s_req, s_gnt, s_rvalid, s_we, err_o;
  logic [3:0]  s_be;
`ifdef DBUS_ARB_PERF_EN
  logic        stall_clr;
  logic [31:0] stall_cnt;
`endif

  logic [31:0] ma [2];
  logic [31:0] mw [2];
  logic        mwe [2];
  logic [3:0]  mbe [2];
  assign m_addr  = {ma[1], ma[0]};
  assign m_wdata = {mw[1], mw[0]};
  assign m_we    = {mwe[1], mwe[0]};
  assign m_be    = {mbe[1], mbe[0]};

  int n_cmp = 0;
  int n_bad = 0;
  int sbq[$];

  dbus_arbiter dut (
    .clk(clk), .rst_n(rst_n), .m_req(m_req), .m_gnt(m_gnt), .m_rvalid(m_rvalid),
    .m_addr(m_addr), .m_we(m_we), .m_be(m_be), .m_wdata(m_wdata), .m_rdata(m_rdata),
    .s_req(s_req), .s_gnt(s_gnt), .s_rvalid(s_rvalid), .s_addr(s_addr), .s_we(s_we),
    .s_be(s_be), .s_wdata(s_wdata), .s_rdata(s_rdata), .err_o(err_o)
`ifdef DBUS_ARB_PERF_EN
    , .stall_clr(stall_clr), .stall_cnt(stall_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] req;
    logic       gnt;
    logic       rv;
    logic       e_sreq;
    logic [1:0] e_gnt;
    logic [1:0] e_rv;
    int         e_sel;
  } vec_t;
  vec_t tbl [10];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Inputs change 1ns after the rising edge; outputs are checked on the falling edge.
  task automatic drive(input logic [1:0] req, input logic g, input logic rv);
    @(posedge clk);
    #1;
    m_req    = req;
    s_gnt    = g;
    s_rvalid = rv;
    s_rdata  = $urandom;
    @(negedge clk);
  endtask

  task automatic sb_check();
    int e;
    if (m_rvalid != 2'b00) begin
      if (sbq.size() == 0) chk("sb_unexpected_rvalid", m_rvalid, 2'b00);
      else begin
        e = sbq.pop_front();
        chk("sb_rvalid_order", m_rvalid, 2'b01 << e);
        chk("sb_rdata", m_rdata, s_rdata);
      end
    end
  endtask

  task automatic sb_drain();
    chk("sb_drain", sbq.size(), 0);
    sbq.delete();
  endtask

  initial begin
    int ep;
    ma[0] = 32'h100;  mw[0] = 32'hDEADBEEF; mwe[0] = 1'b1; mbe[0] = 4'hF;
    ma[1] = 32'h300;  mw[1] = 32'h12345678; mwe[1] = 1'b0; mbe[1] = 4'h3;
    m_req = 2'b00; s_gnt = 1'b0; s_rvalid = 1'b0; s_rdata = '0;
`ifdef DBUS_ARB_PERF_EN
    stall_clr = 1'b0;
`endif
    rst_n = 1'b0;

    tbl[0] = '{2'b00, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 0};
    tbl[1] = '{2'b01, 1'b1, 1'b0, 1'b1, 2'b01, 2'b00, 0};
    tbl[2] = '{2'b00, 1'b1, 1'b1, 1'b0, 2'b00, 2'b01, 0};
    tbl[3] = '{2'b10, 1'b1, 1'b0, 1'b1, 2'b10, 2'b00, 1};
    tbl[4] = '{2'b10, 1'b1, 1'b0, 1'b1, 2'b10, 2'b00, 1};
    tbl[5] = '{2'b11, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 0};
    tbl[6] = '{2'b11, 1'b1, 1'b1, 1'b0, 2'b00, 2'b10, 0};
    tbl[7] = '{2'b11, 1'b1, 1'b0, 1'b1, 2'b01, 2'b00, 0};
    tbl[8] = '{2'b00, 1'b0, 1'b1, 1'b0, 2'b00, 2'b10, 0};
    tbl[9] = '{2'b00, 1'b0, 1'b1, 1'b0, 2'b00, 2'b01, 0};

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_m_gnt", m_gnt, 2'b00);
    chk("rst_m_rvalid", m_rvalid, 2'b00);
    chk("rst_s_req", s_req, 1'b0);
    chk("rst_err", err_o, 1'b0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Single master, back-to-back full FIFO, pop-then-push-next-cycle.
    for (int i = 0; i < 10; i++) begin
      drive(tbl[i].req, tbl[i].gnt, tbl[i].rv);
      chk($sformatf("v%0d_s_req", i), s_req, tbl[i].e_sreq);
      chk($sformatf("v%0d_m_gnt", i), m_gnt, tbl[i].e_gnt);
      chk($sformatf("v%0d_m_rvalid", i), m_rvalid, tbl[i].e_rv);
      if (tbl[i].e_sreq) begin
        chk($sformatf("v%0d_s_addr", i), s_addr, ma[tbl[i].e_sel]);
        chk($sformatf("v%0d_s_wdata", i), s_wdata, mw[tbl[i].e_sel]);
        chk($sformatf("v%0d_s_we", i), s_we, mwe[tbl[i].e_sel]);
        chk($sformatf("v%0d_s_be", i), s_be, mbe[tbl[i].e_sel]);
      end
      if (tbl[i].e_rv != 2'b00) chk($sformatf("v%0d_m_rdata", i), m_rdata, s_rdata);
    end

    // Stalled grant: master0 frozen while master1 (next in round-robin) waits.
    ma[0] = 32'h200;
    drive(2'b01, 1'b0, 1'b0);
    chk("stall0_s_req", s_req, 1'b1);
    chk("stall0_s_addr", s_addr, 32'h200);
    chk("stall0_m_gnt", m_gnt, 2'b00);
    for (int i = 1; i < 3; i++) begin
      drive(2'b11, 1'b0, 1'b0);
      chk($sformatf("stall%0d_s_addr", i), s_addr, 32'h200);
      chk($sformatf("stall%0d_m_gnt", i), m_gnt, 2'b00);
    end
    drive(2'b11, 1'b1, 1'b0);
    chk("stall3_m_gnt", m_gnt, 2'b01);
    sbq.push_back(0);
    drive(2'b10, 1'b1, 1'b0);
    chk("stall4_m_gnt", m_gnt, 2'b10);
    chk("stall4_s_addr", s_addr, 32'h300);
    sbq.push_back(1);
    drive(2'b00, 1'b0, 1'b1); sb_check();
    drive(2'b00, 1'b0, 1'b1); sb_check();
    sb_drain();

    // Master drops req during HOLD: s_req follows it down, then arbitration resumes.
    drive(2'b01, 1'b0, 1'b0);
    chk("drop0_s_req", s_req, 1'b1);
    drive(2'b00, 1'b0, 1'b0);
    chk("drop1_s_req", s_req, 1'b0);
    chk("drop1_m_gnt", m_gnt, 2'b00);

    // Contention: alternating grants, responses in grant order.
    ep = 0;
    for (int k = 0; k < 8; k++) begin
      drive(2'b11, 1'b1, k > 0);
      sb_check();
      chk($sformatf("rr%0d_m_gnt", k), m_gnt, 2'b01 << ep);
      sbq.push_back(ep);
      ep = (ep + 1) % 2;
    end
    drive(2'b00, 1'b0, 1'b1); sb_check();
    sb_drain();

    // Spurious response with empty FIFO, then reset in the middle of a transaction.
    drive(2'b00, 1'b0, 1'b1);
    chk("spur_m_rvalid", m_rvalid, 2'b00);
    drive(2'b00, 1'b0, 1'b0);
    chk("spur_err", err_o, 1'b1);
    drive(2'b00, 1'b0, 1'b0);
    chk("spur_err_sticky", err_o, 1'b1);
    drive(2'b01, 1'b1, 1'b0);
    chk("pre_rst_m_gnt", m_gnt, 2'b01);
    @(posedge clk);
    #1;
    rst_n = 1'b0; m_req = 2'b00; s_gnt = 1'b0; s_rvalid = 1'b1;
    @(negedge clk);
    chk("mid_rst_err", err_o, 1'b0);
    chk("mid_rst_s_req", s_req, 1'b0);
    chk("mid_rst_m_rvalid", m_rvalid, 2'b00);
    @(posedge clk);
    #1;
    rst_n = 1'b1; s_rvalid = 1'b0;
    drive(2'b11, 1'b1, 1'b0);
    chk("post_rst_m_gnt", m_gnt, 2'b01);
    sbq.push_back(0);
    drive(2'b00, 1'b0, 1'b1); sb_check();
    chk("post_rst_err", err_o, 1'b0);
    sb_drain();

`ifdef DBUS_ARB_PERF_EN
    stall_clr = 1'b1;
    drive(2'b00, 1'b0, 1'b0);
    stall_clr = 1'b0;
    repeat (5) drive(2'b01, 1'b0, 1'b0);
    drive(2'b00, 1'b0, 1'b0);
    chk("stall_cnt_5", stall_cnt, 32'd5);
    stall_clr = 1'b1;
    drive(2'b00, 1'b0, 1'b0);
    chk("stall_cnt_clr", stall_cnt, 32'd0);
    stall_clr = 1'b0;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/dbus_arbiter.md
Name: dbus_arbiter

Overview:
- Shares one OBI-style data slave port (req/gnt/rvalid) between N data masters: the core data port and DMA/CAN-controller masters.
- Sits between the master ports and the data-side interconnect/memory.
- Round-robin arbitration; the address phase is held stable until grant.
- An in-order ID FIFO routes each response (rvalid/rdata) back to the master that issued the request.

Parameters:
- NUM_MASTERS, 2, number of requesting masters (2..8).
- MAX_OUTSTANDING, 2, maximum granted-but-unanswered transactions (1..8).

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- m_req  input  NUM_MASTERS  per-master request
- m_gnt  output  NUM_MASTERS  per-master grant
- m_rvalid  output  NUM_MASTERS  per-master response valid
- m_addr  input  NUM_MASTERS*32  per-master address, master i at bits [32i+31:32i]
- m_we  input  NUM_MASTERS  per-master write enable
- m_be  input  NUM_MASTERS*4  per-master byte enables
- m_wdata  input  NUM_MASTERS*32  per-master write data
- m_rdata  output  32  response data, broadcast to all masters (qualified by m_rvalid)
- s_req  output  1  slave request
- s_gnt  input  1  slave grant
- s_rvalid  input  1  slave response valid
- s_addr  output  32  selected address
- s_we  output  1  selected write enable
- s_be  output  4  selected byte enables
- s_wdata  output  32  selected write data
- s_rdata  input  32  slave read data
- err_o  output  1  sticky protocol error (rvalid with empty ID FIFO)

Behaviour:
- Reset is asynchronous and active-low; all state is cleared on assertion.
  - Reset values: rr_ptr=0, state=IDLE, FIFO empty (count=0), err_o=0.
  - All m_gnt, m_rvalid and s_req are 0 during and after reset until requests arrive.
- FSM IDLE:
  - Winner = first requesting master at or after rr_ptr, circularly.
  - s_req = winner exists AND count<MAX_OUTSTANDING.
  - s_addr/we/be/wdata are muxed combinationally from the winner.
  - Zero-cycle latency: a request can be granted in the same cycle it is raised.
- Handshake = s_req & s_gnt:
  - m_gnt[sel]=1 in that cycle.
  - Push sel into the ID FIFO.
  - rr_ptr <= (sel+1) mod NUM_MASTERS.
  - State stays IDLE.
- s_req=1 without s_gnt: go to HOLD and register sel.
- FSM HOLD:
  - Selection is frozen to the registered sel regardless of other requests (OBI address stability).
  - s_req stays 1; return to IDLE on handshake.
  - A master must not drop req before gnt. If it does, the arbiter still holds sel and forwards m_req[sel] (s_req falls), then returns to IDLE.
- Full (count==MAX_OUTSTANDING): s_req=0, no grant.
  - A pop in the same cycle does NOT enable a push; this avoids any combinational path from s_rvalid to s_req.
  - The push becomes possible the next cycle.
- Response: s_rvalid pops the FIFO head; m_rvalid[head]=s_rvalid in the same cycle; m_rdata=s_rdata.
- Simultaneous push and pop (not full): count unchanged, pointers both advance.
- s_rvalid while FIFO empty: ignored (no m_rvalid, no pop), err_o<=1 until reset.
- Write transactions also occupy a FIFO slot; OBI returns rvalid for writes.
- Responses are assumed in-order from the slave (OBI guarantee).

Optional Feature:
- Macro DBUS_ARB_PERF_EN.
- Defined:
  - Adds output stall_cnt, 32 bits: increments each cycle some m_req is high and no handshake occurs; saturates at 0xFFFFFFFF.
  - Adds input stall_clr, 1 bit: synchronous clear, priority over increment.
  - Reset value 0.
- Undefined: ports and counter absent; behaviour otherwise identical.

Decomposition:
- config_pkg gains NUM_DBUS_MASTERS (default 2) and DBUS_MAX_OUTSTANDING (default 2).
- config_pkg gains typedef dbus_mid_t = logic [$clog2(NUM_DBUS_MASTERS)-1:0].
- FSM state enum {IDLE, HOLD} lives locally in the module.
- One sub-module: dbus_arb_idfifo.
  - Parametric depth/width, in-order sync FIFO, async active-low reset.
  - Ports: push, push_id, pop, head_id, full, empty.

Test Plan:
- Single master: m_req=01, s_gnt=1 always, write addr 0x100 wdata 0xDEADBEEF -> m_gnt[0] same cycle; s_addr=0x100; rvalid next cycle -> m_rvalid=01.
- Contention: both req continuously, s_gnt=1, 1-cycle rvalid -> grants alternate 0,1,0,1; m_rvalid order matches grant order.
- Stalled grant: master0 req with s_gnt=0 for 3 cycles, master1 raises req during the stall -> s_addr stays master0's 0x200; master1 granted only after master0.
- Full FIFO: MAX_OUTSTANDING=2, two grants, no rvalid -> s_req=0 on third request; first rvalid pops head -> s_req=1 next cycle.
- Spurious s_rvalid at reset-empty FIFO -> no m_rvalid; err_o=1 sticky; rst_n low mid-transaction clears FIFO, err_o, rr_ptr=0.
- With DBUS_ARB_PERF_EN: 5 cycles req with s_gnt=0 -> stall_cnt=5; stall_clr pulse -> 0.
